// File: rtl/column_window_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : column_window_feeder_if
// Description : Pixel-stream in / 7-pixel column out bundle for the
//               column_window_feeder. The master drives pixels; the slave
//               (the feeder) returns the registered column.
// Revision    : 1.0 - initial release
// ============================================================================
interface column_window_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              frame_start;
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic [DATA_W-1:0] out3;
    logic [DATA_W-1:0] out4;
    logic [DATA_W-1:0] out5;
    logic [DATA_W-1:0] out6;
    logic              out_valid;
    logic [ADDR_W-1:0] out_x;
    logic              out_eol;

    modport master (
        output frame_start, pix_in, pix_valid,
        input  out0, out1, out2, out3, out4, out5, out6,
        input  out_valid, out_x, out_eol
    );

    modport slave (
        input  frame_start, pix_in, pix_valid,
        output out0, out1, out2, out3, out4, out5, out6,
        output out_valid, out_x, out_eol
    );
endinterface
`default_nettype wire

// File: rtl/column_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : column_window_feeder
// Description : Raster-to-column front end for a 7-tap vertical median.
//               Six line buffers hold lines y-1..y-6; each accepted pixel
//               produces the column rows y-6..y at the same x, one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module column_window_feeder #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    column_window_feeder_if.slave  bus
);

    localparam int                c_LINES    = 6;
    localparam int                c_IDX_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [ADDR_W-1:0] c_LAST_X   = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [2:0]        c_ROW_FULL = 3'd6;
    localparam logic [2:0]        c_ROW_LAST = 3'd5;

    // Control states: FILL while fewer than six lines of this frame are stored.
    localparam logic [0:0] c_FILL   = 1'b0;
    localparam logic [0:0] c_STREAM = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_x_cnt;
    logic [2:0]        r_row_cnt;

    logic [ADDR_W-1:0] w_x;
    logic [c_IDX_W-1:0] w_idx;
    logic              w_wrap;
    logic              w_accept;

    // Line storage: r_lb[0] = line y-1 .. r_lb[5] = line y-6.
    logic [DATA_W-1:0] r_lb [0:c_LINES-1][0:IMG_WIDTH-1];
    logic [DATA_W-1:0] w_rd [0:c_LINES-1];

    // Registered column: r_col[0] = oldest row, r_col[6] = current row.
    logic [DATA_W-1:0] r_col [0:c_LINES];
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_x;
    logic              r_out_eol;

    // A frame_start pixel is forced to column 0 regardless of the counter.
    assign w_x      = bus.frame_start ? '0 : r_x_cnt;
    assign w_idx    = w_x[c_IDX_W-1:0];
    assign w_wrap   = (w_x == c_LAST_X);
    assign w_accept = bus.pix_valid;

    // Asynchronous read of all six lines at the current column (pre-write data).
    always_comb begin
        for (int k = 0; k < c_LINES; k++) begin
            w_rd[k] = r_lb[k][w_idx];
        end
    end

    // Cascade write: new pixel enters line y-1, each older line takes the one above.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_lb[0][w_idx] <= bus.pix_in;
            for (int k = 1; k < c_LINES; k++) begin
                r_lb[k][w_idx] <= w_rd[k-1];
            end
        end
    end

    // Column and row counters; row count saturates once six lines are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt   <= '0;
            r_row_cnt <= '0;
        end else if (bus.frame_start) begin
            r_x_cnt   <= w_accept ? ADDR_W'(1) : '0;
            r_row_cnt <= '0;
        end else if (w_accept) begin
            r_x_cnt <= w_wrap ? '0 : r_x_cnt + ADDR_W'(1);
            if (w_wrap && (r_row_cnt != c_ROW_FULL)) begin
                r_row_cnt <= r_row_cnt + 3'd1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter STREAM on the wrap that completes line 5; frame_start restarts fill.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.frame_start) begin
            w_state_nxt = c_FILL;
        end else if (w_accept && w_wrap && (r_row_cnt == c_ROW_LAST)) begin
            w_state_nxt = c_STREAM;
        end
    end

    // Output register: capture the column on each accepted pixel, pulse valid once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= c_LINES; k++) begin
                r_col[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_eol   <= 1'b0;
        end else begin
            r_out_valid <= w_accept && !bus.frame_start && (r_state == c_STREAM);
            if (w_accept) begin
                r_col[c_LINES] <= bus.pix_in;
                for (int k = 0; k < c_LINES; k++) begin
                    r_col[c_LINES-1-k] <= w_rd[k];
                end
                r_out_x   <= w_x;
                r_out_eol <= w_wrap;
            end
        end
    end

    assign bus.out0      = r_col[0];
    assign bus.out1      = r_col[1];
    assign bus.out2      = r_col[2];
    assign bus.out3      = r_col[3];
    assign bus.out4      = r_col[4];
    assign bus.out5      = r_col[5];
    assign bus.out6      = r_col[6];
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_eol   = r_out_eol;

endmodule
`default_nettype wire

// File: tb/tb_column_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_window_feeder
// Description : Self-checking bench for column_window_feeder (4-pixel lines).
//               A frame-memory model predicts every registered column.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_column_window_feeder;

    localparam int c_W   = 4;
    localparam int c_DW  = 8;
    localparam int c_AW  = 2;
    localparam int c_MEM = 8192;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    column_window_feeder_if #(.DATA_W(c_DW), .ADDR_W(c_AW)) bus ();

    column_window_feeder #(
        .IMG_WIDTH (c_W),
        .DATA_W    (c_DW),
        .ADDR_W    (c_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the whole current frame, addressed by (row, col).
    logic [7:0] mem [0:c_MEM-1];
    int         m_x;
    int         m_y;
    logic [7:0] e_col [0:6];
    bit         e_known;
    int         e_x;
    bit         e_eol;
    bit         e_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit fs, input bit v, input logic [7:0] p);
        if (r) begin
            m_x = 0; m_y = 0;
            for (int k = 0; k < 7; k++) e_col[k] = 8'h00;
            e_known = 1'b1; e_x = 0; e_eol = 1'b0; e_valid = 1'b0;
        end else begin
            if (fs) begin
                m_x = 0; m_y = 0;
            end
            if (v) begin
                mem[(m_y * c_W + m_x) % c_MEM] = p;
                e_valid  = (m_y >= 6);
                e_known  = (m_y >= 6);
                e_col[6] = p;
                if (m_y >= 6) begin
                    for (int k = 0; k < 6; k++)
                        e_col[k] = mem[((m_y - 6 + k) * c_W + m_x) % c_MEM];
                end
                e_x   = m_x;
                e_eol = (m_x == c_W - 1);
                m_x++;
                if (m_x == c_W) begin
                    m_x = 0;
                    m_y++;
                end
            end else begin
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] obs [0:6];
        obs[0] = bus.out0; obs[1] = bus.out1; obs[2] = bus.out2; obs[3] = bus.out3;
        obs[4] = bus.out4; obs[5] = bus.out5; obs[6] = bus.out6;
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("out_x",     32'(bus.out_x),     32'(e_x));
        chk("out_eol",   32'(bus.out_eol),   32'(e_eol));
        chk("out6",      32'(obs[6]),        32'(e_col[6]));
        if (e_known) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("out%0d", k), 32'(obs[k]), 32'(e_col[k]));
        end
    endtask

    task automatic step(input bit r, input bit fs, input bit v, input logic [7:0] p);
        rst             = r;
        bus.frame_start = fs;
        bus.pix_valid   = v;
        bus.pix_in      = p;
        @(posedge clk);
        model(r, fs, v, p);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = '0;
        m_x = 0; m_y = 0; e_known = 1'b0; e_x = 0; e_eol = 1'b0; e_valid = 1'b0;
        for (int k = 0; k < 7; k++) e_col[k] = 8'h00;
        @(negedge clk);

        // Reset for two cycles.
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out3",      32'(bus.out3),      32'h0);

        // Frame 1: rows 0..6 with pixel = 16*row + col.
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < c_W; c++) begin
                step(0, (r == 0 && c == 0), 1, 8'(16 * r + c));
                if (r == 6 && c == 0) begin
                    chk("first_valid", 32'(bus.out_valid), 32'h1);
                    chk("first_out0",  32'(bus.out0),      32'h00);
                    chk("first_out3",  32'(bus.out3),      32'h30);
                    chk("first_out6",  32'(bus.out6),      32'h60);
                end
                if (r == 6 && c == 3) begin
                    chk("eol_flag", 32'(bus.out_eol), 32'h1);
                    chk("eol_out0", 32'(bus.out0),    32'h03);
                end
            end
        end

        // Row 7 with a three-cycle stall in the middle.
        step(0, 0, 1, 8'h70);
        chk("row7_out0", 32'(bus.out0), 32'h10);
        step(0, 0, 1, 8'h71);
        for (int s = 0; s < 3; s++) begin
            step(0, 0, 0, 8'hEE);
            chk("stall_hold_out6", 32'(bus.out6), 32'h71);
        end
        step(0, 0, 1, 8'h72);
        chk("resume_x", 32'(bus.out_x), 32'h2);
        step(0, 0, 1, 8'h73);

        // Part of row 8, then a new frame with distinct data.
        step(0, 0, 1, 8'h80);
        step(0, 0, 1, 8'h81);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < c_W; c++) begin
                if (r == 7 && c == 2) break;
                step(0, (r == 0 && c == 0), 1, 8'(16 * r + c) ^ 8'hA5);
            end
        end

        // Reset mid-row while streaming, then refill without frame_start.
        step(1, 0, 0, 8'h00);
        chk("midrst_out6", 32'(bus.out6), 32'h0);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < c_W; c++) begin
                step(0, 0, 1, 8'(16 * r + c) ^ 8'h3C);
                if (r == 3 && c == 1) step(0, 0, 0, 8'h00);
            end
        end

        // Randomised traffic: stalls, rare frame restarts and resets.
        for (int i = 0; i < 1500; i++) begin
            bit r_b, fs_b, v_b;
            r_b  = ($urandom_range(0, 999) < 2);
            fs_b = ($urandom_range(0, 999) < 3);
            v_b  = ($urandom_range(0, 9) < 8);
            step(r_b, fs_b, v_b, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
